// File: rtl/wb_ram_slave_if.sv
// ----------------------------------------------------------------------------
// wb_ram_slave_if
// Wishbone B4 registered-feedback bus bundle between one master and the
// wb_ram_slave memory.
//   CYC_I, STB_I, WE_I : cycle, strobe, write enable      (master -> slave)
//   ADR_I              : byte address                      (master -> slave)
//   DAT_I, SEL_I       : write data and byte lane enables  (master -> slave)
//   CTI_I, BTE_I       : cycle type and burst type         (master -> slave)
//   DAT_O              : read data                         (slave -> master)
//   ACK_O, ERR_O, RTY_O: cycle terminations                (slave -> master)
// ----------------------------------------------------------------------------
interface wb_ram_slave_if #(
  parameter int unsigned WB_ADDR_W = 32,
  parameter int unsigned WB_DATA_W = 32
);
  logic                   CYC_I;
  logic                   STB_I;
  logic                   WE_I;
  logic [WB_ADDR_W-1:0]   ADR_I;
  logic [WB_DATA_W-1:0]   DAT_I;
  logic [WB_DATA_W/8-1:0] SEL_I;
  logic [2:0]             CTI_I;
  logic [1:0]             BTE_I;
  logic [WB_DATA_W-1:0]   DAT_O;
  logic                   ACK_O;
  logic                   ERR_O;
  logic                   RTY_O;

  modport slave (
    input  CYC_I, STB_I, WE_I, ADR_I, DAT_I, SEL_I, CTI_I, BTE_I,
    output DAT_O, ACK_O, ERR_O, RTY_O
  );

  modport master (
    output CYC_I, STB_I, WE_I, ADR_I, DAT_I, SEL_I, CTI_I, BTE_I,
    input  DAT_O, ACK_O, ERR_O, RTY_O
  );
endinterface

// File: rtl/wb_ram_slave.sv
// ----------------------------------------------------------------------------
// wb_ram_slave
// Wishbone slave backed by a DEPTH x WB_DATA_W RAM. Classic cycles are
// terminated after WAIT_STATES extra cycles; incrementing bursts (linear or
// wrap-4/8/16) then run with one ACK per cycle. Addresses outside the window
// [BASE_ADDR, BASE_ADDR + DEPTH*WB_DATA_W/8) get ERR_O and never touch memory.
// Ports:
//   RST_I : asynchronous active-low reset
//   CLK_I : clock, rising edge
//   wb    : Wishbone slave bundle (see wb_ram_slave_if); the interface
//           parameters must match WB_ADDR_W / WB_DATA_W here
// ----------------------------------------------------------------------------
module wb_ram_slave #(
  parameter int unsigned          WB_ADDR_W   = 32,
  parameter int unsigned          WB_DATA_W   = 32,
  parameter int unsigned          DEPTH       = 16,
  parameter int unsigned          WAIT_STATES = 0,
  parameter logic [WB_ADDR_W-1:0] BASE_ADDR   = '0
) (
  input  logic          RST_I,
  input  logic          CLK_I,
  wb_ram_slave_if.slave wb
);

  localparam int unsigned          N_LANES   = WB_DATA_W / 8;
  localparam int unsigned          IDX_W     = $clog2(DEPTH);
  localparam int unsigned          BYTE_SH   = $clog2(N_LANES);
  localparam logic [WB_ADDR_W-1:0] SPAN      = WB_ADDR_W'(DEPTH * N_LANES);
  // Only meaningful when WAIT_STATES > 0; WAIT is never entered otherwise.
  localparam logic [3:0]           WAIT_LAST = 4'(WAIT_STATES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_ACK   = 2'd2;
  localparam logic [1:0] S_BURST = 2'd3;

  logic [WB_DATA_W-1:0] r_mem [DEPTH];
  logic [1:0]           r_state;
  logic [3:0]           r_wait_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_in_range;

  logic                 w_req;
  logic [WB_ADDR_W-1:0] w_offset;
  logic                 w_hit;
  logic                 w_ack;
  logic                 w_err;
  logic                 w_wr;
  logic                 w_more;
  logic [IDX_W-1:0]     w_mask;
  logic [IDX_W-1:0]     w_idx_inc;
  logic [IDX_W-1:0]     w_idx_next;

  assign w_req    = wb.CYC_I & wb.STB_I;
  assign w_offset = wb.ADR_I - BASE_ADDR;
  // Below-base addresses wrap to a huge offset, but the explicit >= check
  // keeps the decision independent of where the window sits.
  assign w_hit    = (wb.ADR_I >= BASE_ADDR) && (w_offset < SPAN);
  assign w_more   = (wb.CTI_I == 3'b010);

  // Terminations are qualified by the live CYC_I&STB_I so that a master
  // wait or an abort never produces an ACK/ERR, and ACK/ERR are exclusive.
  assign w_ack = w_req & ((r_state == S_BURST) | ((r_state == S_ACK) & r_in_range));
  assign w_err = w_req & (r_state == S_ACK) & ~r_in_range;
  assign w_wr  = w_ack & wb.WE_I;

  // Wrap bursts only advance the low index bits selected by the mask.
  always_comb begin
    w_mask = '1;
    case (wb.BTE_I)
      2'b01:   w_mask = IDX_W'(4'h3);
      2'b10:   w_mask = IDX_W'(4'h7);
      2'b11:   w_mask = IDX_W'(4'hF);
      default: w_mask = '1;
    endcase
  end

  assign w_idx_inc  = r_idx + IDX_W'(1);
  assign w_idx_next = (r_idx & ~w_mask) | (w_idx_inc & w_mask);

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
      r_idx      <= '0;
      r_in_range <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_idx      <= IDX_W'(w_offset >> BYTE_SH);
            r_in_range <= w_hit;
            r_wait_cnt <= '0;
            r_state    <= (WAIT_STATES > 0) ? S_WAIT : S_ACK;
          end
        end
        S_WAIT: begin
          if (!w_req) begin
            r_state <= S_IDLE;
          end else if (r_wait_cnt == WAIT_LAST) begin
            r_state <= S_ACK;
          end else begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
          end
        end
        S_ACK: begin
          // STB_I low with CYC_I high simply holds the ACK state.
          if (!wb.CYC_I) begin
            r_state <= S_IDLE;
          end else if (w_ack) begin
            if (w_more) begin
              r_idx   <= w_idx_next;
              r_state <= S_BURST;
            end else begin
              r_state <= S_IDLE;
            end
          end else if (w_err) begin
            r_state <= S_IDLE;
          end
        end
        S_BURST: begin
          if (!wb.CYC_I) begin
            r_state <= S_IDLE;
          end else if (w_ack) begin
            r_idx <= w_idx_next;
            if (!w_more) begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // RAM contents are deliberately not reset.
  always_ff @(posedge CLK_I) begin
    if (w_wr) begin
      for (int i = 0; i < int'(N_LANES); i++) begin
        if (wb.SEL_I[i]) begin
          r_mem[r_idx][i*8 +: 8] <= wb.DAT_I[i*8 +: 8];
        end
      end
    end
  end

  assign wb.DAT_O = (w_ack & ~wb.WE_I) ? r_mem[r_idx] : '0;
  assign wb.ACK_O = w_ack;
  assign wb.ERR_O = w_err;
  assign wb.RTY_O = 1'b0;

endmodule

// File: tb/tb_wb_ram_slave.sv
module tb_wb_ram_slave;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  wb_ram_slave_if #(.WB_ADDR_W(32), .WB_DATA_W(32)) wb ();

  wb_ram_slave #(
    .WB_ADDR_W  (32),
    .WB_DATA_W  (32),
    .DEPTH      (16),
    .WAIT_STATES(2),
    .BASE_ADDR  (32'h100)
  ) dut (
    .RST_I(rst_n),
    .CLK_I(clk),
    .wb   (wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Classic single transfer. Called at posedge+1; returns at posedge+1.
  // lat counts clock edges from driving the request to the terminating
  // cycle (request sampled at edge 1, so 2 wait states put ACK at 3).
  // One trailing idle cycle is also watched for stray terminations.
  task automatic wb_classic(input logic we, input logic [31:0] adr,
                            input logic [31:0] dat, input logic [3:0] sel,
                            output logic [31:0] rdata, output int lat,
                            output int n_ack, output int n_err);
    wb.CYC_I = 1'b1; wb.STB_I = 1'b1; wb.WE_I = we;
    wb.ADR_I = adr;  wb.DAT_I = dat;  wb.SEL_I = sel;
    wb.CTI_I = 3'b000; wb.BTE_I = 2'b00;
    lat = -1; n_ack = 0; n_err = 0; rdata = '0;
    for (int n = 0; n < 20; n++) begin
      #1;
      if (wb.ACK_O) n_ack++;
      if (wb.ERR_O) n_err++;
      if (wb.ACK_O || wb.ERR_O) begin
        lat = n; rdata = wb.DAT_O;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    wb.CYC_I = 1'b0; wb.STB_I = 1'b0; wb.WE_I = 1'b0;
    #1;
    if (wb.ACK_O) n_ack++;
    if (wb.ERR_O) n_err++;
    @(posedge clk); #1;
    $display("[TB] classic we=%0d adr=%h dat=%h sel=%b -> rd=%h lat=%0d acks=%0d errs=%0d",
             we, adr, dat, sel, rdata, lat, n_ack, n_err);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    wb.CYC_I = 1'b1; wb.STB_I = 1'b1; wb.ADR_I = 32'h104;
    #1;
    n_tests++;
    if (wb.ACK_O !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b, expected 0", wb.ACK_O); end
    n_tests++;
    if (wb.ERR_O !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b, expected 0", wb.ERR_O); end
    n_tests++;
    if (wb.RTY_O !== 1'b0) begin n_fail++; $display("FAIL reset_rty: got %b, expected 0", wb.RTY_O); end
    n_tests++;
    if (wb.DAT_O !== 32'h0) begin n_fail++; $display("FAIL reset_dat: got %h, expected 0", wb.DAT_O); end
    @(posedge clk); #1;
    wb.CYC_I = 1'b0; wb.STB_I = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    $display("[TB] reset done");
  endtask

  task automatic test_classic;
    logic [31:0] rd; int lat, na, ne;
    wb_classic(1'b1, 32'h104, 32'hDEADBEEF, 4'hF, rd, lat, na, ne);
    n_tests++;
    if (lat !== 3) begin n_fail++; $display("FAIL classic_wr_latency: got %0d, expected 3", lat); end
    n_tests++;
    if (na !== 1 || ne !== 0) begin n_fail++; $display("FAIL classic_wr_term: acks %0d errs %0d, expected 1/0", na, ne); end
    wb_classic(1'b0, 32'h104, 32'h0, 4'hF, rd, lat, na, ne);
    n_tests++;
    if (lat !== 3) begin n_fail++; $display("FAIL classic_rd_latency: got %0d, expected 3", lat); end
    n_tests++;
    if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL classic_rd_data: got %h, expected deadbeef", rd); end
  endtask

  task automatic test_byte_lanes;
    logic [31:0] rd; int lat, na, ne;
    wb_classic(1'b1, 32'h108, 32'h11223344, 4'hF, rd, lat, na, ne);
    wb_classic(1'b1, 32'h108, 32'h0000AB00, 4'b0010, rd, lat, na, ne);
    wb_classic(1'b0, 32'h108, 32'h0, 4'hF, rd, lat, na, ne);
    n_tests++;
    if (rd !== 32'h1122AB44) begin n_fail++; $display("FAIL byte_lane_data: got %h, expected 1122ab44", rd); end
  endtask

  task automatic test_out_of_range;
    logic [31:0] rd; int lat, na, ne;
    wb_classic(1'b1, 32'h100, 32'h600D0100, 4'hF, rd, lat, na, ne);
    wb_classic(1'b1, 32'h13C, 32'h600D013C, 4'hF, rd, lat, na, ne);
    wb_classic(1'b0, 32'h140, 32'h0, 4'hF, rd, lat, na, ne);
    n_tests++;
    if (ne !== 1 || na !== 0) begin n_fail++; $display("FAIL oor_read_term: errs %0d acks %0d, expected 1/0", ne, na); end
    n_tests++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL oor_read_dat: got %h, expected 0", rd); end
    n_tests++;
    if (lat !== 3) begin n_fail++; $display("FAIL oor_err_latency: got %0d, expected 3", lat); end
    wb_classic(1'b1, 32'h140, 32'h0BAD0BAD, 4'hF, rd, lat, na, ne);
    n_tests++;
    if (ne !== 1 || na !== 0) begin n_fail++; $display("FAIL oor_write_term: errs %0d acks %0d, expected 1/0", ne, na); end
    wb_classic(1'b1, 32'h0FC, 32'h0BAD0BAD, 4'hF, rd, lat, na, ne);
    wb_classic(1'b0, 32'h100, 32'h0, 4'hF, rd, lat, na, ne);
    n_tests++;
    if (rd !== 32'h600D0100) begin n_fail++; $display("FAIL oor_mem_100: got %h, expected 600d0100", rd); end
    wb_classic(1'b0, 32'h13C, 32'h0, 4'hF, rd, lat, na, ne);
    n_tests++;
    if (rd !== 32'h600D013C) begin n_fail++; $display("FAIL oor_mem_13c: got %h, expected 600d013c", rd); end
  endtask

  task automatic test_wrap_burst;
    logic [31:0] rd; int lat, na, ne;
    logic [31:0] got [4];
    int          at  [4];
    logic [31:0] exp_d [4];
    int beats;
    exp_d[0] = 32'hA3A30000; exp_d[1] = 32'hA0A00000;
    exp_d[2] = 32'hA1A10000; exp_d[3] = 32'hA2A20000;
    wb_classic(1'b1, 32'h100, 32'hA0A00000, 4'hF, rd, lat, na, ne);
    wb_classic(1'b1, 32'h104, 32'hA1A10000, 4'hF, rd, lat, na, ne);
    wb_classic(1'b1, 32'h108, 32'hA2A20000, 4'hF, rd, lat, na, ne);
    wb_classic(1'b1, 32'h10C, 32'hA3A30000, 4'hF, rd, lat, na, ne);
    wb.CYC_I = 1'b1; wb.STB_I = 1'b1; wb.WE_I = 1'b0; wb.SEL_I = 4'hF;
    wb.ADR_I = 32'h10C; wb.BTE_I = 2'b01;
    beats = 0;
    for (int c = 0; c < 30 && beats < 4; c++) begin
      wb.CTI_I = (beats == 3) ? 3'b111 : 3'b010;
      #1;
      if (wb.ACK_O) begin got[beats] = wb.DAT_O; at[beats] = c; beats++; end
      @(posedge clk); #1;
    end
    // Burst must be over: a live strobe now must not be acked.
    wb.CTI_I = 3'b010;
    #1;
    n_tests++;
    if (wb.ACK_O !== 1'b0) begin n_fail++; $display("FAIL wrap_after_last: ack %b, expected 0", wb.ACK_O); end
    @(posedge clk); #1;
    wb.CYC_I = 1'b0; wb.STB_I = 1'b0; wb.CTI_I = 3'b000; wb.BTE_I = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (beats !== 4) begin n_fail++; $display("FAIL wrap_beats: got %0d, expected 4", beats); end
    for (int i = 0; i < beats; i++) begin
      $display("[TB] wrap beat %0d data=%h cycle=%0d", i, got[i], at[i]);
      n_tests++;
      if (got[i] !== exp_d[i]) begin n_fail++; $display("FAIL wrap_data%0d: got %h, expected %h", i, got[i], exp_d[i]); end
      n_tests++;
      if (at[i] !== 3 + i) begin n_fail++; $display("FAIL wrap_cycle%0d: got %0d, expected %0d", i, at[i], 3 + i); end
    end
  endtask

  task automatic test_burst_gap;
    logic [31:0] rd; int lat, na, ne;
    int acks, gap, gap_ack, last_at;
    wb_classic(1'b1, 32'h118, 32'h0000118C, 4'hF, rd, lat, na, ne);
    wb.CYC_I = 1'b1; wb.WE_I = 1'b1; wb.SEL_I = 4'hF;
    wb.ADR_I = 32'h104; wb.BTE_I = 2'b00;
    acks = 0; gap = 0; gap_ack = 0; last_at = -1;
    for (int c = 0; c < 40 && acks < 5; c++) begin
      if (acks == 2 && gap < 2) begin wb.STB_I = 1'b0; gap++; end
      else wb.STB_I = 1'b1;
      wb.DAT_I = 32'hB0B00000 + acks;
      wb.CTI_I = (acks == 4) ? 3'b111 : 3'b010;
      #1;
      if (wb.ACK_O) begin
        if (!wb.STB_I) gap_ack++;
        acks++; last_at = c;
      end
      @(posedge clk); #1;
    end
    wb.CYC_I = 1'b0; wb.STB_I = 1'b0; wb.WE_I = 1'b0; wb.CTI_I = 3'b000;
    @(posedge clk); #1;
    $display("[TB] gap burst acks=%0d gap_acks=%0d last_cycle=%0d", acks, gap_ack, last_at);
    n_tests++;
    if (acks !== 5) begin n_fail++; $display("FAIL gap_acks: got %0d, expected 5", acks); end
    n_tests++;
    if (gap_ack !== 0) begin n_fail++; $display("FAIL gap_ack_in_gap: got %0d, expected 0", gap_ack); end
    n_tests++;
    if (last_at !== 9) begin n_fail++; $display("FAIL gap_last_cycle: got %0d, expected 9", last_at); end
    for (int i = 0; i < 5; i++) begin
      wb_classic(1'b0, 32'h104 + 4 * i, 32'h0, 4'hF, rd, lat, na, ne);
      n_tests++;
      if (rd !== 32'hB0B00000 + i) begin n_fail++; $display("FAIL gap_mem%0d: got %h, expected %h", i, rd, 32'hB0B00000 + i); end
    end
    wb_classic(1'b0, 32'h118, 32'h0, 4'hF, rd, lat, na, ne);
    n_tests++;
    if (rd !== 32'h0000118C) begin n_fail++; $display("FAIL gap_mem_beyond: got %h, expected 0000118c", rd); end
  endtask

  task automatic test_abort;
    logic [31:0] rd; int lat, na, ne, stray;
    wb_classic(1'b1, 32'h120, 32'h00000055, 4'hF, rd, lat, na, ne);
    wb.CYC_I = 1'b1; wb.STB_I = 1'b1; wb.WE_I = 1'b1; wb.SEL_I = 4'hF;
    wb.ADR_I = 32'h120; wb.DAT_I = 32'h00000099; wb.CTI_I = 3'b000;
    stray = 0;
    #1;
    if (wb.ACK_O || wb.ERR_O) stray++;
    @(posedge clk); #1;
    wb.CYC_I = 1'b0; wb.STB_I = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (wb.ACK_O || wb.ERR_O || wb.DAT_O !== 32'h0) stray++;
      @(posedge clk); #1;
    end
    wb.WE_I = 1'b0;
    n_tests++;
    if (stray !== 0) begin n_fail++; $display("FAIL abort_outputs: %0d active cycles, expected 0", stray); end
    wb_classic(1'b0, 32'h120, 32'h0, 4'hF, rd, lat, na, ne);
    n_tests++;
    if (rd !== 32'h00000055) begin n_fail++; $display("FAIL abort_no_write: got %h, expected 00000055", rd); end
    n_tests++;
    if (lat !== 3) begin n_fail++; $display("FAIL abort_then_latency: got %0d, expected 3", lat); end
  endtask

  task automatic test_reset_mid_burst;
    logic [31:0] rd; int lat, na, ne, beats;
    wb.CYC_I = 1'b1; wb.STB_I = 1'b1; wb.WE_I = 1'b0; wb.SEL_I = 4'hF;
    wb.ADR_I = 32'h100; wb.BTE_I = 2'b00; wb.CTI_I = 3'b010;
    beats = 0;
    for (int c = 0; c < 30 && beats < 2; c++) begin
      #1;
      if (wb.ACK_O) beats++;
      @(posedge clk); #1;
    end
    n_tests++;
    if (beats !== 2) begin n_fail++; $display("FAIL rst_burst_beats: got %0d, expected 2", beats); end
    rst_n = 1'b0;
    #1;
    $display("[TB] reset mid-burst ack=%b err=%b rty=%b dat=%h", wb.ACK_O, wb.ERR_O, wb.RTY_O, wb.DAT_O);
    n_tests++;
    if ({wb.ACK_O, wb.ERR_O, wb.RTY_O} !== 3'b000) begin n_fail++; $display("FAIL rst_mid_term: got %b, expected 000", {wb.ACK_O, wb.ERR_O, wb.RTY_O}); end
    n_tests++;
    if (wb.DAT_O !== 32'h0) begin n_fail++; $display("FAIL rst_mid_dat: got %h, expected 0", wb.DAT_O); end
    @(posedge clk); #1;
    n_tests++;
    if (wb.ACK_O !== 1'b0) begin n_fail++; $display("FAIL rst_hold_ack: got %b, expected 0", wb.ACK_O); end
    wb.CYC_I = 1'b0; wb.STB_I = 1'b0; wb.CTI_I = 3'b000;
    rst_n = 1'b1;
    @(posedge clk); #1;
    wb_classic(1'b0, 32'h100, 32'h0, 4'hF, rd, lat, na, ne);
    n_tests++;
    if (lat !== 3) begin n_fail++; $display("FAIL rst_after_latency: got %0d, expected 3", lat); end
    n_tests++;
    if (rd !== 32'hA0A00000) begin n_fail++; $display("FAIL rst_mem_kept: got %h, expected a0a00000", rd); end
  endtask

  initial begin
    rst_n = 1'b0;
    wb.CYC_I = 1'b0; wb.STB_I = 1'b0; wb.WE_I = 1'b0;
    wb.ADR_I = '0; wb.DAT_I = '0; wb.SEL_I = '0;
    wb.CTI_I = 3'b000; wb.BTE_I = 2'b00;
    test_reset();
    test_classic();
    test_byte_lanes();
    test_out_of_range();
    test_wrap_burst();
    test_burst_gap();
    test_abort();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
